// File: rtl/counter_pkg.sv
// Mode encodings and default sizing shared by the up/down counter and its wrap-event counter.
// Constants only: no logic, no latency, no flow control.
package counter_pkg;
   localparam logic [1:0] MODE_UP1    = 2'b00;
   localparam logic [1:0] MODE_DN1    = 2'b01;
   localparam logic [1:0] MODE_DNSTEP = 2'b10;
   localparam logic [1:0] MODE_LOAD   = 2'b11;

   localparam int DEF_WIDTH  = 4;
   localparam int DEF_STEP   = 3;
   localparam int DEF_WRAP_W = 8;
endpackage

// File: rtl/wrap_event_counter.sv
// Saturating event counter with synchronous clear; 1-cycle latency, always accepts inc.
// Clear wins over increment; holds at all-ones once full.
module wrap_event_counter #(
   parameter int WRAP_W = 8
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic              clr,
   input  logic              inc,
   output logic [WRAP_W-1:0] cnt
);
   logic [WRAP_W-1:0] r_cnt;
   logic              w_full;

   assign w_full = &r_cnt;

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (inc && !w_full) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign cnt = r_cnt;
endmodule

// File: rtl/param_updown_counter.sv
// WIDTH-bit up/down/step/load counter with registered wrap pulse and wrap count; 1-cycle latency, no backpressure.
// Define COUNTER_SAT_EN to clamp at the range ends instead of wrapping.
module param_updown_counter
   import counter_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STEP   = DEF_STEP,
   parameter int WRAP_W = DEF_WRAP_W
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic              enable,
   input  logic [1:0]        modo,
   input  logic [WIDTH-1:0]  D,
   output logic [WIDTH-1:0]  Q,
   output logic              rco,
   output logic [WRAP_W-1:0] wrap_cnt
);
   localparam logic [WIDTH:0] ONE_EXT  = (WIDTH+1)'(1);
   localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

   logic [WIDTH-1:0] r_q;
   logic             r_rco;
   logic [WIDTH:0]   w_sum;
   logic             w_wrap;
   logic [WIDTH-1:0] w_q_nxt;
   logic             w_clr;
   logic             w_inc;

   // The extra top bit carries out of an increment or borrows out of a decrement: that is the wrap flag.
   always_comb begin
      w_sum = '0;
      unique case (modo)
         MODE_UP1:    w_sum = {1'b0, r_q} + ONE_EXT;
         MODE_DN1:    w_sum = {1'b0, r_q} - ONE_EXT;
         MODE_DNSTEP: w_sum = {1'b0, r_q} - STEP_EXT;
         default:     w_sum = {1'b0, D};
      endcase
      w_wrap  = w_sum[WIDTH];
      w_q_nxt = w_sum[WIDTH-1:0];
`ifdef COUNTER_SAT_EN
      if (w_wrap) begin
         if (modo == MODE_DNSTEP) w_q_nxt = '0;
         else                     w_q_nxt = r_q;
      end
`endif
   end

   assign w_clr = !enable || (modo == MODE_LOAD);
   assign w_inc = enable && w_wrap;

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         r_q   <= '0;
         r_rco <= 1'b0;
      end else if (!enable) begin
         r_q   <= '0;
         r_rco <= 1'b0;
      end else begin
         r_q   <= w_q_nxt;
         r_rco <= w_wrap;
      end
   end

   wrap_event_counter #(
      .WRAP_W (WRAP_W)
   ) u_wrap_cnt (
      .clk     (clk),
      .reset_L (reset_L),
      .clr     (w_clr),
      .inc     (w_inc),
      .cnt     (wrap_cnt)
   );

   assign Q   = r_q;
   assign rco = r_rco;
endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter at WIDTH=4, STEP=3, WRAP_W=8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_param_updown_counter;
   logic       clk;
   logic       reset_L;
   logic       enable;
   logic [1:0] modo;
   logic [3:0] D;
   logic [3:0] Q;
   logic       rco;
   logic [7:0] wrap_cnt;

   int n_checks;
   int n_fails;

   param_updown_counter #(
      .WIDTH  (4),
      .STEP   (3),
      .WRAP_W (8)
   ) dut (
      .clk      (clk),
      .reset_L  (reset_L),
      .enable   (enable),
      .modo     (modo),
      .D        (D),
      .Q        (Q),
      .rco      (rco),
      .wrap_cnt (wrap_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_all(input string tag, input int eq, input int erco, input int ewc);
      check({tag, ".Q"}, 32'(Q), 32'(eq));
      check({tag, ".rco"}, 32'(rco), 32'(erco));
      check({tag, ".wrap_cnt"}, 32'(wrap_cnt), 32'(ewc));
   endtask

   initial begin
      int q_m;
      int wraps;
      int cycles;
      n_checks = 0;
      n_fails  = 0;
      reset_L = 1'b0;
      enable  = 1'b0;
      modo    = 2'b00;
      D       = 4'd0;

      #2;
      check_all("reset_init", 0, 0, 0);
      @(negedge clk);
      reset_L = 1'b1;
      enable  = 1'b1;
      modo    = 2'b00;

`ifdef COUNTER_SAT_EN
      for (int i = 1; i <= 15; i++) step();
      check_all("sat_up_reach", 15, 0, 0);
      for (int i = 1; i <= 3; i++) begin
         step();
         check_all($sformatf("sat_up_hold%0d", i), 15, 1, i);
      end
`else
      // Up count from 0: 1..15, 0 (wrap), 1.
      for (int i = 1; i <= 17; i++) begin
         step();
         check($sformatf("up%0d.Q", i), 32'(Q), 32'(i % 16));
         check($sformatf("up%0d.rco", i), 32'(rco), (i == 16) ? 32'd1 : 32'd0);
      end
      check("up.wrap_cnt", 32'(wrap_cnt), 32'd1);
`endif

      modo = 2'b11;
      D    = 4'd2;
      step();
      check_all("load2", 2, 0, 0);
      modo = 2'b10;
`ifdef COUNTER_SAT_EN
      step();
      check_all("sat_dnstep", 0, 1, 1);
      modo = 2'b11;
      D    = 4'd9;
      step();
`else
      step();
      check_all("dnstep1", 15, 1, 1);
      step();
      check_all("dnstep2", 12, 0, 1);
      step();
      check_all("dnstep3", 9, 0, 1);
`endif

      // Asynchronous reset mid-cycle while Q=9.
      check("pre_reset.Q", 32'(Q), 32'd9);
      #2;
      reset_L = 1'b0;
      #1;
      check_all("async_reset", 0, 0, 0);
      @(negedge clk);
      reset_L = 1'b1;
      check_all("reset_held", 0, 0, 0);

      enable = 1'b1;
      modo   = 2'b01;
`ifdef COUNTER_SAT_EN
      step();
      check_all("sat_dn1", 0, 1, 1);
      step();
      check_all("sat_dn1b", 0, 1, 2);
`else
      step();
      check_all("dn1_wrap", 15, 1, 1);
      step();
      check_all("dn1_next", 14, 0, 1);

      // Long mode-10 run: 300 wraps, wrap_cnt must stop at 255.
      modo   = 2'b10;
      q_m    = 14;
      wraps  = 1;
      cycles = 0;
      while (wraps < 300 && cycles < 2000) begin
         step();
         cycles++;
         if (q_m < 3) wraps++;
         q_m = (q_m - 3) & 15;
         check("sat_run.Q", 32'(Q), 32'(q_m));
         check("sat_run.wrap_cnt", 32'(wrap_cnt), 32'((wraps > 255) ? 255 : wraps));
      end
      check("sat_run.done", 32'(wraps), 32'd300);
      check("sat_run.rco_last", 32'(rco), 32'd1);
      check("sat_run.final_cnt", 32'(wrap_cnt), 32'd255);
`endif

      enable = 1'b0;
      modo   = 2'b00;
      D      = 4'd7;
      step();
      check_all("clear", 0, 0, 0);
      step();
      check_all("clear_hold", 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end
endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
- Parametrised successor of the team's 4-bit mode-controlled counter.
- WIDTH-bit register with four modes: up by 1, down by 1, down by STEP, and parallel load.
- Registered ripple-carry-out pulse on every wrap, plus a saturating count of wrap events.
- Sits in the tarea counter datapath; the companion scoreboard checks it cycle by cycle.

Parameters:
- WIDTH, 4, counter width in bits (>=2).
- STEP, 3, decrement used in mode 2'b10; legal range 1 <= STEP < 2**WIDTH.
- WRAP_W, 8, width of the wrap-event counter.

Ports:
- clk  input  1  rising-edge clock.
- reset_L  input  1  asynchronous reset, active low.
- enable  input  1  1 = operate per modo; 0 = synchronous clear.
- modo  input  2  00 up1, 01 down1, 10 downSTEP, 11 load D.
- D  input  WIDTH  load value for mode 11.
- Q  output  WIDTH  counter value, registered.
- rco  output  1  registered one-cycle wrap pulse.
- wrap_cnt  output  WRAP_W  number of wraps since last clear; saturates.

Behaviour:
- Reset: reset_L=0 forces Q=0, rco=0 and wrap_cnt=0 immediately, independent of clk. Release is sampled at the next rising edge.
- All other updates occur on posedge clk. Every output is a flop; latency is 1 cycle from inputs to Q/rco/wrap_cnt.
- enable=0: Q<=0, rco<=0, wrap_cnt<=0, regardless of modo or D.
- enable=1, modo=00:
  - Q<=Q+1 mod 2**WIDTH.
  - Wrap when Q==all-ones: Q becomes 0 and rco<=1.
- enable=1, modo=01:
  - Q<=Q-1 mod 2**WIDTH.
  - Wrap when Q==0: Q becomes all-ones and rco<=1.
- enable=1, modo=10:
  - Q<=Q-STEP mod 2**WIDTH.
  - Wrap when Q<STEP and rco<=1. For WIDTH=4, STEP=3: 2->15, 1->14, 0->13.
- enable=1, modo=11: Q<=D and rco<=0; wrap_cnt<=0.
- rco is 0 on every non-wrapping cycle, so it is exactly one cycle wide per wrap. Back-to-back wraps give consecutive 1s.
- wrap_cnt increments on every cycle in which rco is being set to 1. It holds at all-ones and never rolls over.
- Arithmetic: compute in WIDTH+1 bits. Bit WIDTH of the result is the wrap flag; the lower WIDTH bits become Q.
- Mode change takes effect on the same edge it is sampled. No internal state besides Q, rco and wrap_cnt.
- Reset asserted mid-count overrides everything. After release, counting restarts from 0 on the first enabled edge.

Optional Feature:
- Macro: COUNTER_SAT_EN.
- Defined: saturating instead of wrapping.
  - modo=00 at all-ones holds Q.
  - modo=01 at 0 holds Q.
  - modo=10 with Q<STEP sets Q<=0.
  - In each of these cases rco<=1 on every cycle the clamp occurs (a level while clamped), and wrap_cnt counts each clamped cycle.
- Undefined: modular wrap exactly as in Behaviour.
- Load and clear behaviour are identical in both builds.

Decomposition:
- Package counter_pkg:
  - Mode constants MODE_UP1=2'b00, MODE_DN1=2'b01, MODE_DNSTEP=2'b10, MODE_LOAD=2'b11.
  - Default WIDTH/STEP/WRAP_W localparams.
- One sub-module, wrap_event_counter: WRAP_W saturating counter with inputs clk, reset_L, clr, inc.
- Next-value arithmetic stays inline in param_updown_counter.

Test Plan (WIDTH=4, STEP=3, WRAP_W=8):
- reset_L=0 pulse mid-cycle while Q=9 -> Q=0, rco=0, wrap_cnt=0 immediately, before the next edge.
- enable=1, modo=00 from Q=0 for 17 edges -> Q sequence 1..15,0,1; rco=1 only on the edge producing 0; wrap_cnt=1.
- modo=11 D=2, then modo=10 for 3 edges -> Q=2, 15 (rco=1), 12, 9; wrap_cnt=1 (it is cleared by the load).
- modo=01 from Q=0 -> Q=15, rco=1; next edge Q=14, rco=0.
- Mode-10 wrap sequence held for 300 wraps -> wrap_cnt saturates at 255; enable=0 -> Q=0, rco=0, wrap_cnt=0.
- With COUNTER_SAT_EN defined, modo=00 at Q=15 for 3 edges -> Q stays 15, rco=1 each edge, wrap_cnt increments by 3.
